z80_bus_mem_cycle: RTL and testbench

//  Executes one Z80 memory machine cycle (read or write) on the external bus for the core sequencer:

---
 rtl/z80_bus_mem_cycle.sv | 166 ++++++++++++++++
 tb/tb_z80_bus_mem_cycle.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_mem_cycle.sv
// Z80 memory machine cycle executor (T1/T2/[TW]/T3); optional /WAIT support via Z80_BUS_WAIT_EN.
// Latency: accept -> rsp_valid in 3 cycles + wait states; req_ready only in IDLE and T3.
module z80_bus_mem_cycle #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   output logic        bus_dout_en,
   input  logic [7:0]  bus_din,
   output logic        mreq_n,
   output logic        rd_n,
   output logic        wr_n,
`ifdef Z80_BUS_WAIT_EN
   input  logic        wait_n,
`endif
   output logic        trc_valid,
   output logic        trc_wr,
   output logic [15:0] trc_addr,
   output logic [7:0]  trc_data,
   output logic [7:0]  trc_waits,
   output logic        trc_err
);

   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   state_t      state_q, state_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic        err_q, err_d;
   logic        wait_s;
   logic        accept;

`ifdef Z80_BUS_WAIT_EN
   assign wait_s = wait_n;
`else
   assign wait_s = 1'b1;
`endif

   assign req_ready = (state_q == S_IDLE) || (state_q == S_T3);
   assign accept    = req_valid && req_ready;
   assign bus_addr  = addr_q;
   assign rsp_rdata = rdata_q;

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      wcnt_d      = wcnt_q;
      err_d       = err_q;
      mreq_n      = 1'b1;
      rd_n        = 1'b1;
      wr_n        = 1'b1;
      bus_dout_en = 1'b0;
      bus_dout    = 8'h00;
      rsp_valid   = 1'b0;
      trc_valid   = 1'b0;
      trc_wr      = 1'b0;
      trc_addr    = 16'h0000;
      trc_data    = 8'h00;
      trc_waits   = 8'h00;
      trc_err     = 1'b0;

      // Strobes are asserted for the whole active part of the cycle; wr_n waits for T2.
      if (state_q == S_T1 || state_q == S_T2 || state_q == S_TW) begin
         mreq_n      = 1'b0;
         rd_n        = wr_q;
         bus_dout_en = wr_q;
         bus_dout    = wr_q ? wdata_q : 8'h00;
         if (state_q != S_T1) begin
            wr_n = ~wr_q;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_T1;
            end
         end
         S_T1: begin
            state_d = S_T2;
         end
         S_T2: begin
            if (!wait_s) begin
               state_d = S_TW;
               wcnt_d  = wcnt_q + 8'd1;
            end else begin
               state_d = S_T3;
               if (!wr_q) begin
                  rdata_d = bus_din;
               end
            end
         end
         S_TW: begin
            if (!wait_s && (wcnt_q < MAX_W)) begin
               wcnt_d = wcnt_q + 8'd1;
            end else begin
               state_d = S_T3;
               err_d   = ~wait_s;
               if (!wr_q) begin
                  rdata_d = bus_din;
               end
            end
         end
         S_T3: begin
            rsp_valid = 1'b1;
            trc_valid = 1'b1;
            trc_wr    = wr_q;
            trc_addr  = addr_q;
            trc_data  = wr_q ? wdata_q : rdata_q;
            trc_waits = wcnt_q;
            trc_err   = err_q;
            state_d   = accept ? S_T1 : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Request is captured once; later input changes cannot disturb the running cycle.
      if (accept) begin
         wr_d    = req_wr;
         addr_d  = req_addr;
         wdata_d = req_wdata;
         wcnt_d  = 8'd0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         addr_q  <= 16'h0000;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
         wcnt_q  <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_z80_bus_mem_cycle.sv
// Bench for z80_bus_mem_cycle: vector table plus back-to-back and mid-cycle reset sequences;
// completions are scored against a queue of expected trace records (wait cases need Z80_BUS_WAIT_EN).
module tb_z80_bus_mem_cycle;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_wr;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic [15:0] bus_addr;
   logic [7:0]  bus_dout;
   logic        bus_dout_en;
   logic [7:0]  bus_din;
   logic        mreq_n, rd_n, wr_n;
`ifdef Z80_BUS_WAIT_EN
   logic        wait_n;
`endif
   logic        trc_valid, trc_wr, trc_err;
   logic [15:0] trc_addr;
   logic [7:0]  trc_data, trc_waits;

   always #5 clk = ~clk;

   z80_bus_mem_cycle #(.MAX_WAIT(MAXW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_dout_en(bus_dout_en), .bus_din(bus_din),
      .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
`ifdef Z80_BUS_WAIT_EN
      .wait_n(wait_n),
`endif
      .trc_valid(trc_valid), .trc_wr(trc_wr), .trc_addr(trc_addr), .trc_data(trc_data),
      .trc_waits(trc_waits), .trc_err(trc_err)
   );

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  din;
      int          low;
   } vec_t;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  data;
      logic [7:0]  rdata;
      logic [7:0]  waits;
      logic        err;
      int          cyc0;
   } exp_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb[$];
   logic [7:0] last_rd = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_wait(input logic v);
`ifdef Z80_BUS_WAIT_EN
      wait_n = v;
`else
      if (v === 1'bx) $display("wait_n not present");
`endif
   endtask

   function automatic int eff_low(input int low);
`ifdef Z80_BUS_WAIT_EN
      return low;
`else
      return (low < 0) ? low : 0;
`endif
   endfunction

   task automatic push_exp(input vec_t v);
      exp_t e;
      int   lw;
      lw      = eff_low(v.low);
      e.wr    = v.wr;
      e.addr  = v.addr;
      e.data  = v.wr ? v.wdata : v.din;
      if (!v.wr) last_rd = v.din;
      e.rdata = last_rd;
      e.waits = 8'((lw > MAXW) ? MAXW : lw);
      e.err   = (lw > MAXW);
      e.cyc0  = cyc;
      sb.push_back(e);
   endtask

   // Completion monitor and bus-protocol invariants.
   always @(negedge clk) begin : mon
      exp_t e;
      if (reset_n) begin
         chk("rd_wr_overlap", {31'd0, (!rd_n && !wr_n)}, 0);
         chk("wr_without_mreq", {31'd0, (!wr_n && mreq_n)}, 0);
         chk("trc_valid_eq_rsp", {31'd0, trc_valid}, {31'd0, rsp_valid});
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("trc_wr", {31'd0, trc_wr}, {31'd0, e.wr});
               chk("trc_addr", {16'd0, trc_addr}, {16'd0, e.addr});
               chk("trc_data", {24'd0, trc_data}, {24'd0, e.data});
               chk("trc_waits", {24'd0, trc_waits}, {24'd0, e.waits});
               chk("trc_err", {31'd0, trc_err}, {31'd0, e.err});
               chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
               chk("latency", cyc - e.cyc0, 3 + int'(e.waits));
            end
         end
      end
   end

   task automatic chk_active(input vec_t v, input bit t1);
      chk("mreq_n_act", {31'd0, mreq_n}, 0);
      chk("rd_n_act", {31'd0, rd_n}, {31'd0, v.wr});
      chk("wr_n_act", {31'd0, wr_n}, t1 ? 1 : {31'd0, !v.wr});
      chk("dout_en_act", {31'd0, bus_dout_en}, {31'd0, v.wr});
      chk("bus_dout_act", {24'd0, bus_dout}, v.wr ? {24'd0, v.wdata} : 0);
      chk("bus_addr_act", {16'd0, bus_addr}, {16'd0, v.addr});
      chk("req_ready_busy", {31'd0, req_ready}, 0);
   endtask

   task automatic chk_released();
      chk("mreq_n_t3", {31'd0, mreq_n}, 1);
      chk("rd_n_t3", {31'd0, rd_n}, 1);
      chk("wr_n_t3", {31'd0, wr_n}, 1);
      chk("dout_en_t3", {31'd0, bus_dout_en}, 0);
      chk("req_ready_t3", {31'd0, req_ready}, 1);
   endtask

   // One isolated cycle from IDLE; returns at the T3 sampling point.
   task automatic run_op(input vec_t v);
      bit done;
      int lw;
      lw = eff_low(v.low);
      @(negedge clk);
      req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata; bus_din = v.din;
      push_exp(v);
      @(negedge clk);
      req_valid = 1'b0; req_wr = !v.wr; req_addr = ~v.addr; req_wdata = ~v.wdata;
      chk_active(v, 1'b1);
      done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (rsp_valid) begin
            chk_released();
            done = 1'b1;
         end else begin
            chk_active(v, 1'b0);
            set_wait(n < lw ? 1'b0 : 1'b1);
         end
      end
      set_wait(1'b1);
      if (!done) begin
         chk("rsp_timeout", 1, 0);
         sb.delete();
      end
   endtask

   vec_t vt[9];
   vec_t va, vb;

   initial begin
      vt[0] = '{wr: 1'b1, addr: 16'h1234, wdata: 8'hA5, din: 8'h00, low: 0};
      vt[1] = '{wr: 1'b0, addr: 16'h8000, wdata: 8'h00, din: 8'h3C, low: 0};
      vt[2] = '{wr: 1'b1, addr: 16'hFFFF, wdata: 8'h00, din: 8'h5A, low: 0};
      vt[3] = '{wr: 1'b0, addr: 16'h0000, wdata: 8'h77, din: 8'hFF, low: 0};
      vt[4] = '{wr: 1'b1, addr: 16'hABCD, wdata: 8'h3C, din: 8'h00, low: 2};
      vt[5] = '{wr: 1'b0, addr: 16'h4321, wdata: 8'h00, din: 8'hC3, low: 1};
      vt[6] = '{wr: 1'b1, addr: 16'h00FF, wdata: 8'h81, din: 8'h00, low: 10};
      vt[7] = '{wr: 1'b0, addr: 16'h5555, wdata: 8'h00, din: 8'h96, low: 4};
      vt[8] = '{wr: 1'b0, addr: 16'hAAAA, wdata: 8'h00, din: 8'h69, low: 5};

      reset_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
      bus_din = 8'h00;
      set_wait(1'b1);
      #12;
      chk("rst_mreq_n", {31'd0, mreq_n}, 1);
      chk("rst_rd_n", {31'd0, rd_n}, 1);
      chk("rst_wr_n", {31'd0, wr_n}, 1);
      chk("rst_dout_en", {31'd0, bus_dout_en}, 0);
      chk("rst_bus_addr", {16'd0, bus_addr}, 0);
      chk("rst_bus_dout", {24'd0, bus_dout}, 0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
      chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 0);
      chk("rst_trc_valid", {31'd0, trc_valid}, 0);
      chk("rst_trc_addr", {16'd0, trc_addr}, 0);
      chk("rst_trc_waits", {24'd0, trc_waits}, 0);
      chk("rst_trc_err", {31'd0, trc_err}, 0);
      chk("rst_req_ready", {31'd0, req_ready}, 1);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_op(vt[i]);
      end
      @(negedge clk);
      chk("idle_holds_addr", {16'd0, bus_addr}, {16'd0, vt[8].addr});
      chk("idle_mreq_n", {31'd0, mreq_n}, 1);

      // Back-to-back: read accepted in the write's T3; inputs changed mid-cycle are ignored.
      va = '{wr: 1'b1, addr: 16'h2468, wdata: 8'h5E, din: 8'h00, low: 0};
      vb = '{wr: 1'b0, addr: 16'h1357, wdata: 8'h00, din: 8'hE1, low: 0};
      @(negedge clk);
      req_valid = 1'b1; req_wr = va.wr; req_addr = va.addr; req_wdata = va.wdata;
      push_exp(va);
      @(negedge clk);
      req_wr = vb.wr; req_addr = vb.addr; req_wdata = vb.wdata; bus_din = vb.din;
      chk_active(va, 1'b1);
      @(negedge clk);
      chk_active(va, 1'b0);
      @(negedge clk);
      chk("b2b_rsp_a", {31'd0, rsp_valid}, 1);
      chk_released();
      push_exp(vb);
      @(negedge clk);
      req_valid = 1'b0;
      chk_active(vb, 1'b1);
      @(negedge clk);
      chk_active(vb, 1'b0);
      @(negedge clk);
      chk("b2b_rsp_b", {31'd0, rsp_valid}, 1);
      chk_released();

      // Reset during T2 of a write aborts it without a completion.
      va = '{wr: 1'b1, addr: 16'hBEEF, wdata: 8'h42, din: 8'h00, low: 0};
      @(negedge clk);
      req_valid = 1'b1; req_wr = va.wr; req_addr = va.addr; req_wdata = va.wdata;
      push_exp(va);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("pre_abort_wr_n", {31'd0, wr_n}, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_wr_n", {31'd0, wr_n}, 1);
      chk("abort_mreq_n", {31'd0, mreq_n}, 1);
      chk("abort_dout_en", {31'd0, bus_dout_en}, 0);
      chk("abort_bus_addr", {16'd0, bus_addr}, 0);
      chk("abort_rsp_valid", {31'd0, rsp_valid}, 0);
      chk("abort_rsp_rdata", {24'd0, rsp_rdata}, 0);
      sb.delete();
      last_rd = 8'h00;
      @(negedge clk);
      chk("abort_no_rsp", {31'd0, rsp_valid}, 0);
      reset_n = 1'b1;
      vb = '{wr: 1'b1, addr: 16'hC0DE, wdata: 8'h18, din: 8'h00, low: 0};
      run_op(vb);
      vb = '{wr: 1'b0, addr: 16'h7001, wdata: 8'h00, din: 8'h4B, low: 0};
      run_op(vb);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
